// File: rtl/ahbl_dma_master.sv
// AHB-lite DMA initiator: copies a block of 32-bit words from a source to a destination
// address, one single NONSEQ read followed by one single NONSEQ write per word.
module ahbl_dma_master #(
    parameter int unsigned W_ADDR    = 32,
    parameter int unsigned W_DATA    = 32,
    parameter int unsigned W_LEN     = 16,
    parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [W_ADDR-1:0] src_addr,
    input  logic [W_ADDR-1:0] dst_addr,
    input  logic [W_LEN-1:0]  len_words,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [W_ADDR-1:0] haddr,
    output logic              hwrite,
    output logic [1:0]        htrans,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic [3:0]        hprot,
    output logic              hmastlock,
    output logic [W_DATA-1:0] hwdata,
    input  logic              hready,
    input  logic              hresp,
    input  logic [W_DATA-1:0] hrdata
);

    typedef enum logic [2:0] {
        StIdle,
        StRdA,
        StRdD,
        StWrA,
        StWrD,
        StFin
    } state_e;

    localparam logic [1:0] TransIdle   = 2'b00;
    localparam logic [1:0] TransNonseq = 2'b10;

    state_e              state_q, state_d;
    logic [W_ADDR-1:0]   src_q, src_d;
    logic [W_ADDR-1:0]   dst_q, dst_d;
    logic [W_LEN-1:0]    rem_q, rem_d;
    logic [W_DATA-1:0]   rbuf_q, rbuf_d;
    logic [W_DATA-1:0]   hwdata_q, hwdata_d;
    logic                err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            src_q    <= '0;
            dst_q    <= '0;
            rem_q    <= '0;
            rbuf_q   <= '0;
            hwdata_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            rem_q    <= rem_d;
            rbuf_q   <= rbuf_d;
            hwdata_q <= hwdata_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        rem_d    = rem_q;
        rbuf_d   = rbuf_q;
        hwdata_d = hwdata_q;
        err_d    = err_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    // Word alignment: low two address bits are dropped.
                    src_d   = src_addr & ~W_ADDR'(3);
                    dst_d   = dst_addr & ~W_ADDR'(3);
                    rem_d   = len_words;
                    err_d   = 1'b0;
                    state_d = (len_words == '0) ? StFin : StRdA;
                end
            end
            StRdA: begin
                if (hready) begin
                    state_d = StRdD;
                end
            end
            StRdD: begin
                if (hready) begin
                    if (hresp) begin
                        err_d   = 1'b1;
                        state_d = StFin;
                    end else begin
                        rbuf_d  = hrdata;
                        state_d = StWrA;
                    end
                end
            end
            StWrA: begin
                if (hready) begin
                    // hwdata only moves on entry to the write data phase.
                    hwdata_d = rbuf_q;
                    state_d  = StWrD;
                end
            end
            StWrD: begin
                if (hready) begin
                    if (hresp) begin
                        err_d   = 1'b1;
                        state_d = StFin;
                    end else begin
                        src_d   = src_q + W_ADDR'(4);
                        dst_d   = dst_q + W_ADDR'(4);
                        rem_d   = rem_q - W_LEN'(1);
                        state_d = (rem_q == W_LEN'(1)) ? StFin : StRdA;
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        haddr  = '0;
        htrans = TransIdle;
        hwrite = 1'b0;
        if (state_q == StRdA) begin
            haddr  = src_q;
            htrans = TransNonseq;
        end else if (state_q == StWrA) begin
            haddr  = dst_q;
            htrans = TransNonseq;
            hwrite = 1'b1;
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StFin);
    assign err       = err_q;
    assign hwdata    = hwdata_q;
    assign hsize     = 3'b010;
    assign hburst    = 3'b000;
    assign hprot     = HPROT_VAL;
    assign hmastlock = 1'b0;

endmodule

// File: tb/tb_ahbl_dma_master.sv
// Bench for ahbl_dma_master: behavioural AHB-lite memory slave with random wait states and
// error injection, checked against expected address/data sequences and cycle counts.
module tb_ahbl_dma_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [15:0] len_words = '0;
    logic        busy, done, err;
    logic [31:0] haddr;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic        hmastlock;
    logic [31:0] hwdata;
    logic        hready = 1'b1;
    logic        hresp = 1'b0;
    logic [31:0] hrdata = '0;

    int checks = 0;
    int failures = 0;

    ahbl_dma_master dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len_words (len_words),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .haddr     (haddr),
        .hwrite    (hwrite),
        .htrans    (htrans),
        .hsize     (hsize),
        .hburst    (hburst),
        .hprot     (hprot),
        .hmastlock (hmastlock),
        .hwdata    (hwdata),
        .hready    (hready),
        .hresp     (hresp),
        .hrdata    (hrdata)
    );

    always #5 clk = ~clk;

    // Slave model state and logs
    logic [31:0] mem [logic [31:0]];
    logic [31:0] rd_log[$];
    logic [31:0] wr_log[$];
    logic [31:0] exp_words[$];
    int unsigned max_wait = 0;
    int          err_on_read = -1;
    int          rd_count = 0;
    int          wait_total = 0;
    int          nonseq_total = 0;
    int          bad_htrans = 0;
    int          stall_bad = 0;
    bit          dphase = 1'b0;
    bit          dwrite = 1'b0;
    bit          wnew = 1'b1;
    bit          prev_stall = 1'b0;
    logic [31:0] daddr = '0;
    logic [31:0] st_addr = '0;
    logic [1:0]  st_trans = '0;
    logic        st_write = 1'b0;
    int          wcnt = 0;
    int          err_step = 0;

    // Slave decides this cycle's response just after the falling edge.
    initial begin : slave
        forever begin
            @(negedge clk);
            #1;
            hready = 1'b1;
            hresp  = 1'b0;
            if (prev_stall) begin
                if (haddr !== st_addr || htrans !== st_trans || hwrite !== st_write) stall_bad++;
                prev_stall = 1'b0;
            end
            if (htrans == 2'b01 || htrans == 2'b11) bad_htrans++;
            if (htrans == 2'b10) nonseq_total++;
            if (rst) begin
                dphase   = 1'b0;
                wnew     = 1'b1;
                err_step = 0;
            end else if (dphase) begin
                if (wnew) begin
                    wnew = 1'b0;
                    wcnt = int'($urandom_range(0, max_wait));
                    if (!dwrite && rd_count == err_on_read) err_step = 1;
                end
                if (err_step == 1) begin
                    hready   = 1'b0;
                    hresp    = 1'b1;
                    err_step = 2;
                end else if (err_step == 2) begin
                    hresp    = 1'b1;
                    err_step = 0;
                    rd_log.push_back(daddr);
                    rd_count++;
                    dphase = 1'b0;
                    wnew   = 1'b1;
                end else if (wcnt > 0) begin
                    hready = 1'b0;
                    wcnt--;
                    wait_total++;
                end else begin
                    if (dwrite) begin
                        mem[daddr] = hwdata;
                        wr_log.push_back(daddr);
                    end else begin
                        hrdata = mem.exists(daddr) ? mem[daddr] : (daddr ^ 32'hDEAD_BEEF);
                        rd_log.push_back(daddr);
                        rd_count++;
                    end
                    dphase = 1'b0;
                    wnew   = 1'b1;
                end
            end else if (htrans == 2'b10) begin
                if (wnew) begin
                    wnew = 1'b0;
                    wcnt = int'($urandom_range(0, max_wait));
                end
                if (wcnt > 0) begin
                    hready = 1'b0;
                    wcnt--;
                    wait_total++;
                    prev_stall = 1'b1;
                    st_addr    = haddr;
                    st_trans   = htrans;
                    st_write   = hwrite;
                end else begin
                    dphase = 1'b1;
                    daddr  = haddr;
                    dwrite = hwrite;
                    wnew   = 1'b1;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // Pulse start, then wait for done (bounded). Optionally pokes start mid-copy.
    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                            input bit poke, output int cyc_out);
        rd_log.delete();
        wr_log.delete();
        wait_total   = 0;
        rd_count     = 0;
        nonseq_total = 0;
        bad_htrans   = 0;
        stall_bad    = 0;
        @(negedge clk);
        src_addr  = s;
        dst_addr  = d;
        len_words = n;
        start     = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        cyc_out = 1;
        while (done !== 1'b1 && cyc_out < 4000) begin
            if (poke && cyc_out == 3) begin
                start     = 1'b1;
                src_addr  = ~s;
                dst_addr  = ~d;
                len_words = n + 16'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc_out++;
        end
        start = 1'b0;
    endtask

    task automatic fill(input logic [31:0] sa, input logic [31:0] da, input int n);
        exp_words.delete();
        for (int i = 0; i < n; i++) begin
            exp_words.push_back($urandom);
            mem[sa + 32'(4 * i)] = exp_words[i];
            mem[da + 32'(4 * i)] = 32'h0BAD_0000 | 32'(i);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, err, htrans, hwrite} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=000000", {busy, done, err, htrans, hwrite});
        end
        checks++;
        if (haddr !== 32'h0 || hwdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_bus haddr=%h hwdata=%h want=0/0", haddr, hwdata);
        end
        checks++;
        if ({hsize, hburst, hprot, hmastlock} !== {3'b010, 3'b000, 4'b0011, 1'b0}) begin
            failures++;
            $display("FAIL const_outputs got=%b want=%b", {hsize, hburst, hprot, hmastlock},
                     {3'b010, 3'b000, 4'b0011, 1'b0});
        end
        rst = 1'b0;
    endtask

    task automatic test_copy(input string name, input logic [31:0] s, input logic [31:0] d,
                             input int n, input int unsigned mw, input bit poke);
        int          cyc;
        logic [31:0] sa, da, ea;
        sa = s & ~32'h3;
        da = d & ~32'h3;
        fill(sa, da, n);
        max_wait = mw;
        run_copy(s, d, 16'(n), poke, cyc);
        checks++;
        if (cyc != 4 * n + 1 + wait_total) begin
            failures++;
            $display("FAIL %s_cycles got=%0d want=%0d", name, cyc, 4 * n + 1 + wait_total);
        end
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL %s_err got=%b want=0", name, err);
        end
        checks++;
        if (rd_log.size() != n || wr_log.size() != n) begin
            failures++;
            $display("FAIL %s_count reads=%0d writes=%0d want=%0d", name, rd_log.size(),
                     wr_log.size(), n);
        end
        for (int i = 0; i < n; i++) begin
            ea = sa + 32'(4 * i);
            if (i < rd_log.size()) begin
                checks++;
                if (rd_log[i] !== ea) begin
                    failures++;
                    $display("FAIL %s_rd_addr[%0d] got=%h want=%h", name, i, rd_log[i], ea);
                end
            end
            ea = da + 32'(4 * i);
            if (i < wr_log.size()) begin
                checks++;
                if (wr_log[i] !== ea) begin
                    failures++;
                    $display("FAIL %s_wr_addr[%0d] got=%h want=%h", name, i, wr_log[i], ea);
                end
            end
            checks++;
            if (mem[ea] !== exp_words[i]) begin
                failures++;
                $display("FAIL %s_data[%0d] got=%h want=%h", name, i, mem[ea], exp_words[i]);
            end
        end
        checks++;
        if (bad_htrans != 0 || stall_bad != 0) begin
            failures++;
            $display("FAIL %s_protocol bad_htrans=%0d unstable_stalls=%0d want=0/0", name,
                     bad_htrans, stall_bad);
        end
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b00) begin
            failures++;
            $display("FAIL %s_after_done done/busy=%b want=00", name, {done, busy});
        end
    endtask

    task automatic test_zero_len();
        int cyc;
        max_wait = 0;
        run_copy(32'h300, 32'h400, 16'd0, 1'b0, cyc);
        checks++;
        if (cyc != 1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL zero_len_done cycle=%0d busy=%b want=1/1", cyc, busy);
        end
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b00) begin
            failures++;
            $display("FAIL zero_len_after done/busy=%b want=00", {done, busy});
        end
        @(negedge clk);
        checks++;
        if (nonseq_total != 0) begin
            failures++;
            $display("FAIL zero_len_traffic nonseq=%0d want=0", nonseq_total);
        end
    endtask

    task automatic test_error();
        int cyc;
        max_wait    = 0;
        err_on_read = 1;
        fill(32'h500, 32'h600, 4);
        run_copy(32'h500, 32'h600, 16'd4, 1'b0, cyc);
        err_on_read = -1;
        checks++;
        if (cyc != 8 || err !== 1'b1) begin
            failures++;
            $display("FAIL error_done cycle=%0d err=%b want=8/1", cyc, err);
        end
        checks++;
        if (wr_log.size() != 1 || rd_log.size() != 2) begin
            failures++;
            $display("FAIL error_count writes=%0d reads=%0d want=1/2", wr_log.size(),
                     rd_log.size());
        end
        checks++;
        if (mem[32'h600] !== exp_words[0] || mem[32'h604] !== 32'h0BAD_0001) begin
            failures++;
            $display("FAIL error_data w0=%h w1=%h want=%h/0bad0001", mem[32'h600],
                     mem[32'h604], exp_words[0]);
        end
        @(negedge clk);
        checks++;
        if ({done, err} !== 2'b01) begin
            failures++;
            $display("FAIL error_sticky done/err=%b want=01", {done, err});
        end
        fill(32'h500, 32'h700, 1);
        run_copy(32'h500, 32'h700, 16'd1, 1'b0, cyc);
        checks++;
        if (err !== 1'b0 || mem[32'h700] !== exp_words[0]) begin
            failures++;
            $display("FAIL error_clear err=%b data=%h want=0/%h", err, mem[32'h700],
                     exp_words[0]);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        max_wait = 0;
        fill(32'h800, 32'h900, 3);
        @(negedge clk);
        src_addr  = 32'h800;
        dst_addr  = 32'h900;
        len_words = 16'd3;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n     = 0;
        while (!(htrans === 2'b10 && hwrite === 1'b1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin
            failures++;
            $display("FAIL reset_mid_reach got=timeout want=write address phase");
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({htrans, busy, done} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_mid htrans/busy/done=%b want=0000", {htrans, busy, done});
        end
        rst = 1'b0;
        test_copy("after_reset", 32'h800, 32'h900, 3, 0, 1'b0);
    endtask

    initial begin : main
        test_reset();
        test_copy("basic", 32'h100, 32'h2000, 3, 0, 1'b0);
        test_zero_len();
        for (int k = 0; k < 3; k++) begin
            test_copy("random", 32'h1000_0000 + 32'($urandom_range(0, 1023) << 2),
                      32'h2000_0000 + 32'($urandom_range(0, 65535)), 8, 3, k == 0);
        end
        test_copy("random_len", 32'h3000_0000, 32'h4000_0002, int'($urandom_range(1, 6)), 2,
                  1'b1);
        test_error();
        test_copy("wrap", 32'hFFFF_FFFC, 32'h0000_0013, 2, 0, 1'b0);
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ahbl_dma_master.md
Name: ahbl_dma_master

Overview:
- AHB-lite initiator that copies a block of 32-bit words from a source address to a destination address.
- Drives the same AHB-lite fabric as the SDRAM/cache slave bridge. Used for boot-image relocation and memory-to-memory moves without CPU involvement.
- Issues only single NONSEQ word transfers. Never issues BUSY or SEQ, because the memory slaves do not support them.
- Each word is a read followed by a write.

Parameters:
- W_ADDR, 32, AHB address width.
- W_DATA, 32, AHB data width; only 32 is supported.
- W_LEN, 16, width of the word-count input.
- HPROT_VAL, 4'b0011, constant driven on hprot (data, privileged).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle request to begin a copy; sampled only in IDLE.
- src_addr  in  W_ADDR  source byte address; bits [1:0] ignored (forced 0).
- dst_addr  in  W_ADDR  destination byte address; bits [1:0] ignored.
- len_words  in  W_LEN  number of words to copy.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse at completion or abort.
- err  out  1  sticky error flag; set on an hresp error, cleared by the next accepted start.
- haddr  out  W_ADDR  AHB address.
- hwrite  out  1  AHB write.
- htrans  out  2  AHB transfer type; only 2'b00 (IDLE) or 2'b10 (NONSEQ).
- hsize  out  3  constant 3'b010.
- hburst  out  3  constant 3'b000 (SINGLE).
- hprot  out  4  constant HPROT_VAL.
- hmastlock  out  1  constant 0.
- hwdata  out  W_DATA  AHB write data.
- hready  in  1  AHB transfer-complete / ready.
- hresp  in  1  AHB error response.
- hrdata  in  W_DATA  AHB read data.

Behaviour:
- Reset values (next clk edge with rst=1, including mid-copy): state=IDLE, busy=0, done=0, err=0, htrans=2'b00, hwrite=0, haddr=0, hwdata=0. Internal address and count registers are cleared. Any outstanding transfer is abandoned.
- States: IDLE, RD_A, RD_D, WR_A, WR_D, FIN.
- IDLE, start=1:
  - latch cur_src={src_addr[W_ADDR-1:2],2'b00}, cur_dst likewise, remaining=len_words; clear err.
  - if len_words==0, go to FIN (no bus traffic); else go to RD_A.
- IDLE, start=0: stay in IDLE.
- start while busy: ignored, with no effect on the copy in progress.
- RD_A: haddr=cur_src, htrans=NONSEQ, hwrite=0. Held stable until sampled hready=1, then go to RD_D.
- RD_D: htrans=IDLE. Wait for hready=1.
  - hresp=0: capture hrdata into the data buffer, go to WR_A.
  - hresp=1: set err, go to FIN.
- WR_A: haddr=cur_dst, htrans=NONSEQ, hwrite=1. Held until hready=1, then go to WR_D.
- WR_D: htrans=IDLE, hwdata=data buffer, held until hready=1.
  - hresp=0: cur_src+=4, cur_dst+=4, remaining-=1; go to FIN if remaining was 1, else go to RD_A.
  - hresp=1: set err, go to FIN.
- FIN: done=1 for exactly one cycle, then go to IDLE. busy is still high in FIN.
- Error response (two cycles: hresp=1/hready=0, then hresp=1/hready=1):
  - the master is already driving htrans=IDLE, so no cancellation is needed;
  - the abort takes effect on the hready=1 cycle;
  - remaining words are not copied.
- Address arithmetic is modulo 2^W_ADDR: a wrap past the top of the address space continues at 0 with no error.
- hwdata is valid only in WR_D. In all other states it holds its last value.
- Latency with a zero-wait slave: start sampled at edge 0, RD_A in cycle 1, each word takes 4 cycles, done is high in cycle 4N+1. Each wait state adds exactly one cycle.
- Address and control outputs never change during an address phase stalled by hready=0.

Test Plan:
- Zero-wait slave, src=0x100, dst=0x2000, len=3, memory words 0xA0,0xA1,0xA2 → dst words 0x2000/4/8 equal 0xA0/A1/A2; done pulses in cycle 13; err=0; htrans never 01/11.
- len_words=0 → no NONSEQ driven; done high in cycle 1 after start; busy high for that one cycle only.
- Random 0-3 wait states per phase, len=8 → data correct; haddr/htrans/hwrite stable while hready=0; cycle count = 33 + total inserted wait states.
- Slave returns a two-cycle ERROR on the read of word 2 of 4 → exactly 1 word written; err=1; done pulse; next start clears err.
- src=0xFFFF_FFFC, dst=0x0000_0013, len=2 → reads at 0xFFFF_FFFC then 0x0; writes at 0x10 then 0x14.
- rst=1 asserted during WR_A of word 1 → next edge htrans=00, busy=0, done=0; a subsequent start runs a full correct copy.
